// File: rtl/furnace_bank.sv
// Multi-zone furnace controller: per-zone saturating temperature datapath,
// door-open alarm debounce and a 4-state status FSM, all updated on the falling edge.
module furnace_bank #(
   parameter int ZONES     = 4,
   parameter int TW        = 7,
   parameter int T_INIT    = 50,
   parameter int T_MAX     = 120,
   parameter int T_MIN     = 25,
   parameter int HEAT_STEP = 5,
   parameter int COOL_STEP = 2,
   parameter int ALARM_DLY = 3
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ZONES-1:0]      door_sig,
   input  logic [ZONES-1:0]      usage,
   input  logic [ZONES*TW-1:0]   setpoint,
   output logic [ZONES*TW-1:0]   furnace_temp,
   output logic [ZONES-1:0]      alarm,
   output logic [2*ZONES-1:0]    zone_state,
   output logic                  alarm_any
);

   localparam int XW = TW + 1;
   typedef logic [XW-1:0] ext_t;

   localparam int   T_RST  = (T_INIT < T_MIN) ? T_MIN : ((T_INIT > T_MAX) ? T_MAX : T_INIT);
   localparam ext_t T_MIN_X = ext_t'(T_MIN);
   localparam ext_t T_MAX_X = ext_t'(T_MAX);
   localparam ext_t HEAT_X  = ext_t'(HEAT_STEP);
   localparam ext_t COOL_X  = ext_t'(COOL_STEP);
   localparam ext_t RST_X   = ext_t'(T_RST);
   localparam logic [7:0] DLY = 8'(ALARM_DLY);

   typedef enum logic [1:0] {
      ST_HEAT  = 2'd0,
      ST_READY = 2'd1,
      ST_DOOR  = 2'd2,
      ST_ALARM = 2'd3
   } zstate_t;

   logic [ZONES-1:0] alarm_nxt_vec;

   for (genvar g = 0; g < ZONES; g++) begin : g_zone
      logic [TW-1:0] temp_q;
      logic [7:0]    cnt_q;
      logic          alarm_q;
      zstate_t       state_q;

      logic          door_open;
      logic          in_use;
      ext_t          sp_raw;
      ext_t          sp_eff;
      ext_t          t_cur;
      ext_t          t_up;
      ext_t          heat_cap;
      ext_t          cool_sp;
      ext_t          cool_min;
      ext_t          t_nxt;
      ext_t          t_sat;
      logic [7:0]    cnt_nxt;
      logic          al_nxt;
      zstate_t       st_nxt;

      assign door_open = door_sig[g];
      assign in_use    = usage[g];
      assign sp_raw    = ext_t'(setpoint[g*TW +: TW]);
      assign sp_eff    = (sp_raw < T_MIN_X) ? T_MIN_X : ((sp_raw > T_MAX_X) ? T_MAX_X : sp_raw);
      assign t_cur     = {1'b0, temp_q};

      // Compare before subtracting so the extended datapath never underflows.
      assign t_up      = t_cur + HEAT_X;
      assign heat_cap  = (t_up > sp_eff) ? sp_eff : t_up;
      assign cool_sp   = (t_cur >= sp_eff + COOL_X) ? (t_cur - COOL_X) : sp_eff;
      assign cool_min  = (t_cur >= T_MIN_X + COOL_X) ? (t_cur - COOL_X) : T_MIN_X;

      always_comb begin
         t_nxt   = t_cur;
         cnt_nxt = 8'd0;
         al_nxt  = 1'b0;
         case ({door_open, in_use})
            2'b00: begin
               if (t_cur < sp_eff) begin
                  t_nxt = heat_cap;
               end else if (t_cur > sp_eff) begin
                  t_nxt = cool_sp;
               end
            end
            2'b01: t_nxt = t_cur;
            2'b10: begin
               t_nxt   = cool_min;
               cnt_nxt = (cnt_q >= DLY) ? DLY : (cnt_q + 8'd1);
               al_nxt  = (cnt_nxt == DLY);
            end
            default: begin
               t_nxt  = cool_min;
               al_nxt = (cool_min == T_MIN_X);
            end
         endcase

         t_sat = (t_nxt < T_MIN_X) ? T_MIN_X : ((t_nxt > T_MAX_X) ? T_MAX_X : t_nxt);

         if (al_nxt) begin
            st_nxt = ST_ALARM;
         end else if (door_open) begin
            st_nxt = ST_DOOR;
         end else if (t_sat == sp_eff) begin
            st_nxt = ST_READY;
         end else begin
            st_nxt = ST_HEAT;
         end
      end

      always_ff @(negedge clock or negedge reset_n) begin
         if (!reset_n) begin
            temp_q  <= RST_X[TW-1:0];
            cnt_q   <= 8'd0;
            alarm_q <= 1'b0;
            state_q <= ST_HEAT;
         end else begin
            temp_q  <= t_sat[TW-1:0];
            cnt_q   <= cnt_nxt;
            alarm_q <= al_nxt;
            state_q <= st_nxt;
         end
      end

      assign furnace_temp[g*TW +: TW] = temp_q;
      assign alarm[g]                 = alarm_q;
      assign zone_state[2*g +: 2]     = state_q;
      assign alarm_nxt_vec[g]         = al_nxt;
   end

   // Registered from the next-values so it lines up with the per-zone alarms.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alarm_any <= 1'b0;
      end else begin
         alarm_any <= |alarm_nxt_vec;
      end
   end

endmodule

// File: doc/furnace_bank.md
# furnace_bank

Multi-zone furnace controller: the parametrised successor of the single-furnace block. It models ZONES independent furnaces, each with a programmable setpoint, configurable heat/cool rates, and an overflow-safe saturating temperature datapath. Each zone runs a small state machine with a debounced door-open alarm. It sits between the per-zone door/usage sensors and the plant supervisor, which reads temperatures, per-zone status and a combined alarm.

## Interface
- ZONES, 4, number of independent furnace zones
- TW, 7, temperature width in bits (unsigned)
- T_INIT, 50, temperature loaded at reset
- T_MAX, 120, absolute upper temperature limit
- T_MIN, 25, absolute lower temperature limit
- HEAT_STEP, 5, rise per edge while heating
- COOL_STEP, 2, fall per edge while cooling or door open
- ALARM_DLY, 3, consecutive door-open idle edges before the alarm asserts (1..255)

Ports (clock and reset first):
- clock  in  1  system clock; all state updates on the falling edge
- reset_n  in  1  asynchronous, active-low reset
- door_sig  in  ZONES  per-zone door open (1 = open)
- usage  in  ZONES  per-zone furnace in use (1 = loaded/operating)
- setpoint  in  ZONES*TW  packed per-zone target temperature; zone i is at [i*TW +: TW]
- furnace_temp  out  ZONES*TW  packed per-zone current temperature
- alarm  out  ZONES  per-zone alarm
- zone_state  out  2*ZONES  packed per-zone FSM state: 0 HEAT, 1 READY, 2 DOOR, 3 ALARM
- alarm_any  out  1  OR of all alarm bits (registered)

## Operation
- Effective setpoint: sp_eff = clamp(setpoint_i, T_MIN, T_MAX).
- Arithmetic is done in TW+1 bits, so intermediate sums never wrap. Every result is saturated into [T_MIN, T_MAX].
- Door counter per zone is 8 bits. It increments, saturating at ALARM_DLY, on each edge with door=1 and usage=0. It clears on any edge with door=0 or usage=1.
- Per-zone next values, evaluated in priority order:
  - door=0, usage=0:
    - if temp < sp_eff: temp += HEAT_STEP, capped at sp_eff.
    - if temp > sp_eff: temp -= COOL_STEP, floored at sp_eff.
    - alarm = 0.
  - door=0, usage=1: temp holds; alarm = 0.
  - door=1, usage=0: temp -= COOL_STEP, floored at T_MIN. Alarm = 1 when the counter's next value equals ALARM_DLY.
  - door=1, usage=1: temp -= COOL_STEP, floored at T_MIN. Alarm = 1 iff the next temp equals T_MIN (undercooled load).
- The zone_state next value is derived from the next-cycle values:
  - ALARM if alarm_next = 1.
  - else DOOR if door = 1.
  - else READY if temp_next == sp_eff.
  - else HEAT.
- Zones are fully independent; no shared arbitration.
- A setpoint change takes effect on the next edge. There is no latching.

## Timing
- All registers update on the negedge of clock.
- reset_n low immediately forces, independent of clock:
  - every furnace_temp to T_INIT, clamped to [T_MIN, T_MAX];
  - alarm, alarm_any and door counters to 0;
  - zone_state to HEAT.
- Reset takes precedence mid-ramp. The first update follows the first falling edge after reset_n rises.
- furnace_temp, alarm and zone_state have 1-edge latency from inputs.
- alarm_any is registered from the alarm next-values, so it is coincident with alarm.
- Door closing while in ALARM: alarm clears and state leaves ALARM on the next edge.
- A door opening and closing within one sample period is invisible, because inputs are sampled only at edges.
- Simultaneous events in different zones are handled in the same edge.
- Inputs are synchronous to clock; no internal synchronisers.

## Test plan
- Reset: hold reset_n=0 with clock toggling → all temps 50, alarm=0, alarm_any=0, zone_state=HEAT. Release → first change only after the next falling edge.
- Ramp: zone 0, door=0, usage=0, setpoint=120, from 50 → 55, 60 … 120 on the 14th edge, with READY on that edge; stays 120/READY afterwards. With setpoint=118 → …115, then 118 (capped), READY.
- Lowered/clamped setpoint: at 120, setpoint changed to 100 → 118, 116 … 100 after 10 edges, then READY. Setpoint=127 behaves as 120; setpoint=10 cools to 25.
- Door alarm debounce: at 120, door=1, usage=0 → temps 118, 116, 114. Alarm and ALARM state assert on the 3rd edge; alarm_any=1. Door=0 → alarm clears next edge; state becomes HEAT and heating resumes.
- Door open with load: temp 30, door=1, usage=1 → 28, 26, 25. Alarm asserts on the edge that reaches 25 and stays while the door is open; no alarm on the earlier edges.
- Multi-zone and reset mid-operation: zone 1 ramping while zone 2 alarms → each zone follows its own rules, and alarm_any=1. Assert reset_n mid-ramp → all zones return to 50 immediately, with counters cleared.
